// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch/button debouncer.
// Each channel runs an input synchroniser, then a four-state FSM with an N-bit
// down-counter. The FSM accepts a new level only after it has held for 2^N
// consecutive enabled samples. Rise and fall ticks are registered one-clock pulses.
module debounce_bank #(
    parameter int              CH     = 4,
    parameter int              N      = 2,
    parameter int              SYNC   = 2,
    parameter logic [CH-1:0]   INVERT = {CH{1'b0}}
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sample_en,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] db_rise,
    output logic [CH-1:0] db_fall,
    output logic          any_tick
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [N-1:0] CNT_LOAD = {N{1'b1}};
    localparam logic [N-1:0] CNT_LAST = N'(1);

    state_t          r_state [CH];
    logic [N-1:0]    r_cnt   [CH];
    logic [SYNC-1:0] r_sync  [CH];
    logic [CH-1:0]   r_level;
    logic [CH-1:0]   r_rise;
    logic [CH-1:0]   r_fall;
    logic            r_any;

    logic [CH-1:0]   w_s;
    logic [CH-1:0]   w_rise_nxt;
    logic [CH-1:0]   w_fall_nxt;

    // Decode the synchronised inputs and the edges that complete a window this clock.
    always_comb begin
        w_s        = '0;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < CH; i++) begin
            w_s[i]        = r_sync[i][SYNC-1];
            w_rise_nxt[i] = sample_en && (r_state[i] == WAIT1) && w_s[i]
                            && (r_cnt[i] == CNT_LAST);
            w_fall_nxt[i] = sample_en && (r_state[i] == WAIT0) && !w_s[i]
                            && (r_cnt[i] == CNT_LAST);
        end
    end

    // Synchroniser chains shift every clock, independent of sample_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) r_sync[i] <= '0;
        end else begin
            for (int i = 0; i < CH; i++)
                r_sync[i] <= {r_sync[i][SYNC-2:0], sw[i] ^ INVERT[i]};
        end
    end

    // Per-channel debounce FSM with a registered level; it advances only on enabled samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                r_state[i] <= ZERO;
                r_cnt[i]   <= '0;
            end
            r_level <= '0;
        end else if (sample_en) begin
            for (int i = 0; i < CH; i++) begin
                case (r_state[i])
                    ZERO: begin
                        if (w_s[i]) begin
                            r_state[i] <= WAIT1;
                            r_cnt[i]   <= CNT_LOAD;
                        end
                    end
                    WAIT1: begin
                        if (!w_s[i]) begin
                            r_state[i] <= ZERO;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_state[i] <= ONE;
                            r_level[i] <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] - CNT_LAST;
                        end
                    end
                    ONE: begin
                        if (!w_s[i]) begin
                            r_state[i] <= WAIT0;
                            r_cnt[i]   <= CNT_LOAD;
                        end
                    end
                    WAIT0: begin
                        if (w_s[i]) begin
                            r_state[i] <= ONE;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_state[i] <= ZERO;
                            r_level[i] <= 1'b0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] - CNT_LAST;
                        end
                    end
                    default: begin
                        r_state[i] <= ZERO;
                        r_cnt[i]   <= '0;
                        r_level[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Ticks are re-evaluated every clock so each pulse lasts exactly one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rise <= '0;
            r_fall <= '0;
            r_any  <= 1'b0;
        end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_any  <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign db_level = r_level;
    assign db_rise  = r_rise;
    assign db_fall  = r_fall;
    assign any_tick = r_any;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (CH=4, N=2, SYNC=2, INVERT=4'b1000).
module tb_debounce_bank;

    logic       clk;
    logic       reset_n;
    logic       sample_en;
    logic [3:0] sw;
    logic [3:0] db_level;
    logic [3:0] db_rise;
    logic [3:0] db_fall;
    logic       any_tick;

    int         checks;
    int         errors;
    logic [3:0] acc;
    logic       accAny;

    debounce_bank #(
        .CH    (4),
        .N     (2),
        .SYNC  (2),
        .INVERT(4'b1000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sample_en(sample_en),
        .sw       (sw),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall),
        .any_tick (any_tick)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the switch pins, then advance a number of clocks and settle 1 ns past the edge.
    task automatic applyStimulus(input logic [3:0] v, input int cycles);
        sw = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        sample_en = 1'b1;
        sw        = 4'b1000;

        // Reset state, channel 3 pin idle high but inverted
        #1;
        checkOutput("reset_level", 32'(db_level), 32'h0);
        checkOutput("reset_ticks", 32'({db_rise, db_fall, any_tick}), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'b1000, 10);
        checkOutput("post_reset_level", 32'(db_level), 32'h0);
        checkOutput("post_reset_any", 32'(any_tick), 32'h0);

        // Channel 0 rise on edge 6, one-clock tick, then fall
        applyStimulus(4'b1001, 5);
        checkOutput("ch0_level_edge5", 32'(db_level), 32'h0);
        applyStimulus(4'b1001, 1);
        checkOutput("ch0_level_edge6", 32'(db_level), 32'h1);
        checkOutput("ch0_rise_edge6", 32'(db_rise), 32'h1);
        checkOutput("ch0_any_edge6", 32'(any_tick), 32'h1);
        applyStimulus(4'b1001, 1);
        checkOutput("ch0_rise_width", 32'({db_rise, any_tick}), 32'h0);
        checkOutput("ch0_level_hold", 32'(db_level), 32'h1);
        applyStimulus(4'b1000, 5);
        checkOutput("ch0_fall_edge5", 32'({db_level, db_fall}), 32'h10);
        applyStimulus(4'b1000, 1);
        checkOutput("ch0_fall_edge6", 32'({db_level, db_fall, any_tick}), 32'h03);
        applyStimulus(4'b1000, 1);
        checkOutput("ch0_fall_width", 32'(db_fall), 32'h0);

        // Channel 1 high for 3 clocks only: rejected
        applyStimulus(4'b1010, 3);
        acc = '0;
        accAny = 1'b0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b1000, 1);
            acc    = acc | db_rise | db_fall | db_level;
            accAny = accAny | any_tick;
        end
        checkOutput("glitch_high", 32'({acc, accAny}), 32'h0);

        // Channel 1 settled high, then a one-clock low dip
        applyStimulus(4'b1010, 10);
        checkOutput("ch1_high", 32'(db_level), 32'h2);
        applyStimulus(4'b1000, 1);
        acc = '0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b1010, 1);
            acc = acc | db_fall | ~db_level;
        end
        checkOutput("glitch_low", 32'(acc), 32'hD);
        applyStimulus(4'b1000, 10);
        checkOutput("ch1_released", 32'(db_level), 32'h0);

        // Sparse sample_en: frozen FSM, then 4 enabled samples
        sample_en = 1'b0;
        applyStimulus(4'b1100, 3);
        applyStimulus(4'b1100, 20);
        checkOutput("freeze_level", 32'(db_level), 32'h0);
        for (int k = 0; k < 4; k++) begin
            sample_en = 1'b1;
            applyStimulus(4'b1100, 1);
            sample_en = 1'b0;
            checkOutput("sparse_level", 32'(db_level[2]), 32'(k == 3));
            checkOutput("sparse_rise", 32'(db_rise), (k == 3) ? 32'h4 : 32'h0);
            applyStimulus(4'b1100, 1);
            checkOutput("sparse_rise_width", 32'(db_rise), 32'h0);
            applyStimulus(4'b1100, 2);
        end
        sample_en = 1'b1;
        applyStimulus(4'b1000, 10);
        checkOutput("ch2_released", 32'(db_level), 32'h0);

        // Inverted channel 3: pin low means active
        applyStimulus(4'b0000, 5);
        checkOutput("ch3_edge5", 32'({db_level, db_rise}), 32'h0);
        applyStimulus(4'b0000, 1);
        checkOutput("ch3_edge6", 32'({db_level, db_rise}), 32'h88);
        applyStimulus(4'b1000, 10);
        checkOutput("ch3_released", 32'(db_level), 32'h0);

        // All channels toggle on the same clock
        applyStimulus(4'b0111, 5);
        checkOutput("all_edge5", 32'({db_rise, any_tick}), 32'h0);
        applyStimulus(4'b0111, 1);
        checkOutput("all_rise", 32'({db_level, db_rise, any_tick}), 32'h1FF);
        applyStimulus(4'b0111, 1);
        checkOutput("all_rise_width", 32'({db_rise, any_tick}), 32'h0);
        applyStimulus(4'b1000, 10);
        checkOutput("all_released", 32'(db_level), 32'h0);

        // Asynchronous reset during a WAIT1 window
        applyStimulus(4'b1010, 10);
        checkOutput("pre_reset_level", 32'(db_level), 32'h2);
        applyStimulus(4'b1011, 4);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 32'({db_level, db_rise, db_fall, any_tick}), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'b1011, 5);
        checkOutput("reset_no_tick", 32'({db_level, db_rise}), 32'h0);
        applyStimulus(4'b1011, 1);
        checkOutput("reset_new_window", 32'({db_level, db_rise}), 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for buttons and slide switches. It is the successor to the single-channel, fixed-N debouncer: per-channel input synchronisers, optional per-channel inversion, a shared sample-enable for long debounce windows without wide counters, and separate rise and fall ticks. It sits between the board pins and the user logic, for example the SRAM test controller's start and step buttons.

## Interface
Parameters:
- CH, 4: number of independent channels (≥1).
- N, 2: counter bits. A new level must hold for 2^N consecutive qualifying samples (N≥1).
- SYNC, 2: synchroniser flop stages per channel (≥2).
- INVERT, {CH{1'b0}}: per-channel mask. Bit i=1 inverts sw[i] before synchronisation (active-low buttons).

Ports:
- clk: input, 1. System clock.
- reset_n: input, 1. Asynchronous, active-low reset. Asserts immediately and releases synchronously to clk edges.
- sample_en: input, 1. Qualifying-sample strobe. Tie to 1 to sample every clock.
- sw: input, CH. Raw asynchronous switch inputs.
- db_level: output, CH. Registered debounced level per channel.
- db_rise: output, CH. One-clk pulse when a channel's db_level goes 0→1.
- db_fall: output, CH. One-clk pulse when a channel's db_level goes 1→0.
- any_tick: output, 1. Registered OR of all db_rise and db_fall bits, aligned with them.

## Operation
- Input path per channel: x = sw[i] ^ INVERT[i], then a SYNC-deep flop chain (reset 0) gives s[i]. The synchroniser shifts every clk, regardless of sample_en.
- Each channel has its own FSM with states ZERO, WAIT1, ONE, WAIT0, plus an N-bit down-counter cnt. The FSM and cnt advance only on clocks with sample_en=1 and hold otherwise.
- ZERO: if s=1, go to WAIT1 and set cnt=2^N−1.
- WAIT1:
  - if s=0, go to ZERO (glitch rejected, no tick);
  - else if cnt==1, go to ONE and pulse db_rise;
  - else cnt=cnt−1.
- ONE: if s=0, go to WAIT0 and set cnt=2^N−1.
- WAIT0:
  - if s=1, go to ONE (no tick);
  - else if cnt==1, go to ZERO and pulse db_fall;
  - else cnt=cnt−1.
- With N=1, cnt is loaded to 1, so the next qualifying sample completes the transition.
- db_level=1 in ONE and WAIT0, 0 otherwise. It is registered and changes on the same edge that enters ONE or ZERO.
- Illegal or unreachable states recover to ZERO with cnt=0 on the next enabled sample.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous tick bits, and any_tick is a single pulse.

## Timing
- Reset values: db_level=0, db_rise=0, db_fall=0, any_tick=0, all FSMs in ZERO, cnt=0, synchronisers 0.
- A channel with INVERT=1 and an idle (high) pin leaves reset at level 0. It stays at 0 because the inverted input is 0.
- Reset mid-operation: all state clears immediately, and pending WAIT counts are discarded without any tick.
- Latency with sample_en=1: sw[i] changes before edge 0, s[i] valid after edge SYNC, and db_level/db_rise update on edge SYNC+2^N. Defaults: edge 6.
- db_rise, db_fall and any_tick are registered, exactly one clk wide, and coincide with the first cycle of the new db_level.
- With a sparse sample_en, the required hold is 2^N enabled samples, not clocks. A tick lasts one clk even if sample_en stays low afterwards.
- A level change must persist through every enabled sample in the window. A single opposite sample restarts the window from the idle state.

## Test plan
- Defaults, sample_en=1, sw[0] 0→1 held: db_level[0] and db_rise[0] rise on edge 6 after the change. db_rise[0] is high for exactly 1 clk and any_tick pulses with it. Releasing sw[0] gives db_fall[0] 6 edges later.
- Glitch: sw[1] high for 3 clks, then low (N=2). No db_level change and no tick. Repeat with a 1-clk low dip while in ONE: level stays 1 and there is no fall tick.
- sample_en every 4th clk, N=2, sw[2] held high: db_level[2] rises after 4 enabled samples (~16 clks after sync). Holding sample_en=0 freezes the FSM indefinitely.
- INVERT=4'b1000, sw[3]=1 through reset: db_level[3]=0 after reset. sw[3]→0 gives db_rise[3] after SYNC+4 edges.
- All channels toggled on the same clk: db_rise=4'hF for one clk and a single any_tick pulse.
- Assert reset_n=0 mid-WAIT1: outputs go to 0 asynchronously. After release, no tick until a full new window completes.
